// File: rtl/rom_access_sequencer.sv
// Sequences SNES and MCU accesses onto the shared cartridge SRAM bus; SNES has absolute priority.
// One access occupies ROM_CYCLE_LEN cycles; MCU_RDY gates a single outstanding MCU request.
module rom_access_sequencer #(
   parameter int ROM_CYCLE_LEN = 7
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        SNES_RD_START,
   input  logic        SNES_WR_END,
   input  logic [23:0] ROM_ADDR,
   input  logic        ROM_HIT,
   input  logic        IS_WRITABLE,
   input  logic [7:0]  SNES_WRDATA,
   output logic [7:0]  SNES_RDDATA,
   input  logic        MCU_RRQ,
   input  logic        MCU_WRQ,
   input  logic [23:0] MCU_ADDR,
   input  logic [7:0]  MCU_WRDATA,
   output logic [7:0]  MCU_RDDATA,
   output logic        MCU_RDY,
   output logic [23:0] RAM_ADDR,
   output logic        RAM_CE_N,
   output logic        RAM_OE_N,
   output logic        RAM_WE_N,
   output logic [7:0]  RAM_DOUT,
   output logic        RAM_DOE,
   input  logic [7:0]  RAM_DIN,
   output logic        SNES_OVF
);

   typedef enum logic [2:0] {IDLE, SNES_RD, SNES_WR, MCU_RD, MCU_WR} state_t;

   localparam logic [3:0] CNT_LAST = 4'(ROM_CYCLE_LEN - 1);
   localparam logic [3:0] WE_LAST  = 4'(ROM_CYCLE_LEN - 2);

   state_t      state, state_nxt;
   logic [3:0]  cnt;

   logic        snes_pend, snes_wr;
   logic [23:0] snes_addr;
   logic [7:0]  snes_data;
   logic        mcu_pend, mcu_wr;
   logic [23:0] mcu_addr;
   logic [7:0]  mcu_data;

   logic        snes_cap_rd, snes_cap_wr, snes_cap, mcu_cap;
   logic        cur_snes_vld, cur_snes_wr, cur_mcu_vld, cur_mcu_wr;
   logic [23:0] cur_snes_addr, cur_mcu_addr;
   logic [7:0]  cur_snes_data, cur_mcu_data;
   logic        last, start, take_snes, take_mcu, wr_state, mcu_state;

   // A strobe in the current cycle is merged with the slot so capture and start can coincide.
   assign snes_cap_rd   = SNES_RD_START & ROM_HIT;
   assign snes_cap_wr   = SNES_WR_END & ROM_HIT & IS_WRITABLE;
   assign snes_cap      = snes_cap_rd | snes_cap_wr;
   assign cur_snes_vld  = snes_pend | snes_cap;
   assign cur_snes_wr   = snes_cap ? ~snes_cap_rd : snes_wr;
   assign cur_snes_addr = snes_cap ? ROM_ADDR : snes_addr;
   assign cur_snes_data = snes_cap ? SNES_WRDATA : snes_data;

   assign mcu_cap       = (MCU_RRQ | MCU_WRQ) & MCU_RDY;
   assign cur_mcu_vld   = mcu_pend | mcu_cap;
   assign cur_mcu_wr    = mcu_cap ? ~MCU_RRQ : mcu_wr;
   assign cur_mcu_addr  = mcu_cap ? MCU_ADDR : mcu_addr;
   assign cur_mcu_data  = mcu_cap ? MCU_WRDATA : mcu_data;

   assign last      = (state != IDLE) && (cnt == CNT_LAST);
   assign start     = (state == IDLE) || last;
   assign take_snes = start & cur_snes_vld;
   assign take_mcu  = start & ~cur_snes_vld & cur_mcu_vld;
   assign wr_state  = (state == SNES_WR) || (state == MCU_WR);
   assign mcu_state = (state == MCU_RD) || (state == MCU_WR);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= (state != IDLE && !last) ? cnt + 4'd1 : 4'd0;
      end
   end

   // Bus strobes decode straight from state so reset deasserts them without waiting for an edge.
   always_comb begin
      state_nxt = state;
      RAM_CE_N  = 1'b1;
      RAM_OE_N  = 1'b1;
      RAM_WE_N  = 1'b1;
      RAM_DOE   = 1'b0;
      if (start) begin
         if (take_snes)
            state_nxt = cur_snes_wr ? SNES_WR : SNES_RD;
         else if (take_mcu)
            state_nxt = cur_mcu_wr ? MCU_WR : MCU_RD;
         else
            state_nxt = IDLE;
      end
      if (state != IDLE)
         RAM_CE_N = 1'b0;
      if (state == SNES_RD || state == MCU_RD)
         RAM_OE_N = 1'b0;
      if (wr_state) begin
         RAM_DOE = 1'b1;
         if (cnt != 4'd0 && cnt <= WE_LAST)
            RAM_WE_N = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         snes_pend   <= 1'b0;
         snes_wr     <= 1'b0;
         snes_addr   <= 24'd0;
         snes_data   <= 8'd0;
         mcu_pend    <= 1'b0;
         mcu_wr      <= 1'b0;
         mcu_addr    <= 24'd0;
         mcu_data    <= 8'd0;
         MCU_RDY     <= 1'b1;
         SNES_OVF    <= 1'b0;
         RAM_ADDR    <= 24'd0;
         RAM_DOUT    <= 8'd0;
         SNES_RDDATA <= 8'd0;
         MCU_RDDATA  <= 8'd0;
      end else begin
         snes_pend <= cur_snes_vld & ~take_snes;
         if (snes_cap) begin
            snes_wr   <= ~snes_cap_rd;
            snes_addr <= ROM_ADDR;
            snes_data <= SNES_WRDATA;
         end
         if (snes_cap && snes_pend)
            SNES_OVF <= 1'b1;

         mcu_pend <= cur_mcu_vld & ~take_mcu;
         if (mcu_cap) begin
            mcu_wr   <= ~MCU_RRQ;
            mcu_addr <= MCU_ADDR;
            mcu_data <= MCU_WRDATA;
            MCU_RDY  <= 1'b0;
         end else if (last && mcu_state) begin
            MCU_RDY  <= 1'b1;
         end

         if (take_snes) begin
            RAM_ADDR <= cur_snes_addr;
            if (cur_snes_wr)
               RAM_DOUT <= cur_snes_data;
         end else if (take_mcu) begin
            RAM_ADDR <= cur_mcu_addr;
            if (cur_mcu_wr)
               RAM_DOUT <= cur_mcu_data;
         end

         if (last && state == SNES_RD)
            SNES_RDDATA <= RAM_DIN;
         if (last && state == MCU_RD)
            MCU_RDDATA <= RAM_DIN;
      end
   end

endmodule

// File: tb/tb_rom_access_sequencer.sv
// Directed bench: stimulus pushes expected SRAM transactions; a bus monitor pops and compares them.
module tb_rom_access_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        SNES_RD_START = 1'b0, SNES_WR_END = 1'b0;
   logic [23:0] ROM_ADDR = 24'd0;
   logic        ROM_HIT = 1'b0, IS_WRITABLE = 1'b0;
   logic [7:0]  SNES_WRDATA = 8'd0;
   logic [7:0]  SNES_RDDATA;
   logic        MCU_RRQ = 1'b0, MCU_WRQ = 1'b0;
   logic [23:0] MCU_ADDR = 24'd0;
   logic [7:0]  MCU_WRDATA = 8'd0;
   logic [7:0]  MCU_RDDATA;
   logic        MCU_RDY;
   logic [23:0] RAM_ADDR;
   logic        RAM_CE_N, RAM_OE_N, RAM_WE_N, RAM_DOE, SNES_OVF;
   logic [7:0]  RAM_DOUT;
   logic [7:0]  RAM_DIN;

   // SRAM model: read byte is the low address byte XOR 0xE0, so 0x012345 returns 0xA5.
   assign RAM_DIN = RAM_ADDR[7:0] ^ 8'hE0;

   rom_access_sequencer #(.ROM_CYCLE_LEN(7)) dut (
      .CLK(CLK), .RST(RST),
      .SNES_RD_START(SNES_RD_START), .SNES_WR_END(SNES_WR_END),
      .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT), .IS_WRITABLE(IS_WRITABLE),
      .SNES_WRDATA(SNES_WRDATA), .SNES_RDDATA(SNES_RDDATA),
      .MCU_RRQ(MCU_RRQ), .MCU_WRQ(MCU_WRQ), .MCU_ADDR(MCU_ADDR),
      .MCU_WRDATA(MCU_WRDATA), .MCU_RDDATA(MCU_RDDATA), .MCU_RDY(MCU_RDY),
      .RAM_ADDR(RAM_ADDR), .RAM_CE_N(RAM_CE_N), .RAM_OE_N(RAM_OE_N),
      .RAM_WE_N(RAM_WE_N), .RAM_DOUT(RAM_DOUT), .RAM_DOE(RAM_DOE),
      .RAM_DIN(RAM_DIN), .SNES_OVF(SNES_OVF)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int          start;
      bit          wr;
      logic [23:0] addr;
      logic [7:0]  data;
      bit          mcu;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic push(input int start, input bit wr, input logic [23:0] addr,
                       input logic [7:0] data, input bit mcu);
      exp_t e;
      e.start = start; e.wr = wr; e.addr = addr; e.data = data; e.mcu = mcu;
      exp_q.push_back(e);
   endtask

   // Bus monitor: each 7-cycle CE_N-low window is one transaction.
   initial begin
      int          run_len = 0;
      int          m_start = 0, we_lo = 0, oe_lo = 0, doe_hi = 0;
      logic [23:0] m_addr = 24'd0;
      logic [7:0]  m_dout = 8'd0;
      bit          m_wr = 1'b0, addr_moved = 1'b0;
      bit          post = 1'b0;
      exp_t        pe, e;
      forever begin
         @(negedge CLK);
         if (RST) begin
            run_len = 0;
            post    = 1'b0;
         end else begin
            if (post) begin
               post = 1'b0;
               if (pe.mcu) begin
                  check("mcu_rdy_after", {31'd0, MCU_RDY}, 32'd1);
                  if (!pe.wr) check("mcu_rddata", {24'd0, MCU_RDDATA}, {24'd0, pe.data});
               end else if (!pe.wr) begin
                  check("snes_rddata", {24'd0, SNES_RDDATA}, {24'd0, pe.data});
               end
            end
            if (!RAM_CE_N) begin
               if (run_len == 0) begin
                  m_start = cyc; m_addr = RAM_ADDR; m_wr = RAM_DOE;
                  we_lo = 0; oe_lo = 0; doe_hi = 0; addr_moved = 1'b0;
               end
               if (RAM_ADDR !== m_addr) addr_moved = 1'b1;
               if (!RAM_WE_N) we_lo++;
               if (!RAM_OE_N) oe_lo++;
               if (RAM_DOE) doe_hi++;
               m_dout = RAM_DOUT;
               run_len++;
               if (run_len == 7) begin
                  run_len = 0;
                  if (exp_q.size() == 0) begin
                     n_vec++;
                     n_fail++;
                     $display("FAIL unexpected_access: got access at cycle %0d addr 0x%0h, expected none",
                              m_start, m_addr);
                  end else begin
                     e = exp_q.pop_front();
                     check("start_cycle", m_start, e.start);
                     check("ram_addr", {8'd0, m_addr}, {8'd0, e.addr});
                     check("addr_stable", {31'd0, addr_moved}, 32'd0);
                     check("is_write", {31'd0, m_wr}, {31'd0, e.wr});
                     if (e.wr) begin
                        check("we_low_cycles", we_lo, 5);
                        check("doe_cycles", doe_hi, 7);
                        check("oe_low_on_write", oe_lo, 0);
                        check("ram_dout", {24'd0, m_dout}, {24'd0, e.data});
                     end else begin
                        check("oe_low_cycles", oe_lo, 7);
                        check("we_low_on_read", we_lo, 0);
                     end
                     pe   = e;
                     post = 1'b1;
                  end
               end
            end else if (run_len != 0) begin
               check("access_len", run_len, 7);
               run_len = 0;
            end
         end
      end
   end

   initial begin
      int t;
      int lo;

      // Reset values
      step(3);
      check("rst_ce_n", {31'd0, RAM_CE_N}, 32'd1);
      check("rst_oe_n", {31'd0, RAM_OE_N}, 32'd1);
      check("rst_we_n", {31'd0, RAM_WE_N}, 32'd1);
      check("rst_doe", {31'd0, RAM_DOE}, 32'd0);
      check("rst_ram_addr", {8'd0, RAM_ADDR}, 32'd0);
      check("rst_ram_dout", {24'd0, RAM_DOUT}, 32'd0);
      check("rst_snes_rddata", {24'd0, SNES_RDDATA}, 32'd0);
      check("rst_mcu_rddata", {24'd0, MCU_RDDATA}, 32'd0);
      check("rst_mcu_rdy", {31'd0, MCU_RDY}, 32'd1);
      check("rst_snes_ovf", {31'd0, SNES_OVF}, 32'd0);
      RST = 1'b0;
      step(2);

      // SNES read from idle
      t = cyc;
      ROM_ADDR = 24'h012345; ROM_HIT = 1'b1; SNES_RD_START = 1'b1;
      push(t + 1, 1'b0, 24'h012345, 8'hA5, 1'b0);
      step();
      SNES_RD_START = 1'b0;
      step(9);

      // Read strobe with ROM_HIT low: no bus activity
      ROM_HIT = 1'b0; ROM_ADDR = 24'h0F0000; SNES_RD_START = 1'b1;
      step();
      SNES_RD_START = 1'b0;
      lo = 0;
      for (int i = 0; i < 10; i++) begin
         if (!RAM_CE_N) lo++;
         step();
      end
      check("no_access_on_miss", lo, 0);

      // Write to a read-only address is dropped
      ROM_HIT = 1'b1; IS_WRITABLE = 1'b0; ROM_ADDR = 24'h00ABCD; SNES_WRDATA = 8'h3C;
      SNES_WR_END = 1'b1;
      step();
      SNES_WR_END = 1'b0;
      lo = 0;
      for (int i = 0; i < 10; i++) begin
         if (!RAM_WE_N) lo++;
         step();
      end
      check("no_we_on_readonly", lo, 0);

      // Writable SNES write
      IS_WRITABLE = 1'b1;
      t = cyc;
      SNES_WR_END = 1'b1;
      push(t + 1, 1'b1, 24'h00ABCD, 8'h3C, 1'b0);
      step();
      SNES_WR_END = 1'b0; IS_WRITABLE = 1'b0;
      step(9);

      // Priority: MCU read running, SNES read queued behind it
      t = cyc;
      MCU_ADDR = 24'h100200; MCU_RRQ = 1'b1;
      push(t + 1, 1'b0, 24'h100200, 8'hE0, 1'b1);
      step();
      MCU_RRQ = 1'b0;
      step();
      ROM_ADDR = 24'h012346; SNES_RD_START = 1'b1;
      push(t + 8, 1'b0, 24'h012346, 8'hA6, 1'b0);
      step();
      SNES_RD_START = 1'b0;
      step(14);

      // Simultaneous SNES read and MCU write
      t = cyc;
      ROM_ADDR = 24'h0200F0; SNES_RD_START = 1'b1;
      MCU_ADDR = 24'h300010; MCU_WRDATA = 8'h77; MCU_WRQ = 1'b1;
      push(t + 1, 1'b0, 24'h0200F0, 8'h10, 1'b0);
      push(t + 8, 1'b1, 24'h300010, 8'h77, 1'b1);
      step();
      SNES_RD_START = 1'b0; MCU_WRQ = 1'b0;
      check("mcu_rdy_low_queued", {31'd0, MCU_RDY}, 32'd0);
      step(13);
      check("mcu_rdy_low_write_end", {31'd0, MCU_RDY}, 32'd0);
      step(4);

      // RRQ and WRQ together: read wins
      t = cyc;
      MCU_ADDR = 24'h300011; MCU_WRDATA = 8'h99; MCU_RRQ = 1'b1; MCU_WRQ = 1'b1;
      push(t + 1, 1'b0, 24'h300011, 8'hF1, 1'b1);
      step();
      MCU_RRQ = 1'b0; MCU_WRQ = 1'b0;
      step(9);

      // Overflow: two SNES strobes during one MCU access
      t = cyc;
      MCU_ADDR = 24'h100300; MCU_RRQ = 1'b1;
      push(t + 1, 1'b0, 24'h100300, 8'hE0, 1'b1);
      step();
      MCU_RRQ = 1'b0;
      step();
      ROM_ADDR = 24'h011111; SNES_RD_START = 1'b1;
      step();
      SNES_RD_START = 1'b0;
      check("ovf_after_first", {31'd0, SNES_OVF}, 32'd0);
      step();
      ROM_ADDR = 24'h022222; SNES_RD_START = 1'b1;
      push(t + 8, 1'b0, 24'h022222, 8'hC2, 1'b0);
      step();
      SNES_RD_START = 1'b0;
      check("ovf_after_second", {31'd0, SNES_OVF}, 32'd1);
      step(14);
      check("ovf_sticky", {31'd0, SNES_OVF}, 32'd1);

      // Reset in the middle of a SNES write
      t = cyc;
      ROM_ADDR = 24'h0000AA; SNES_WRDATA = 8'h55; IS_WRITABLE = 1'b1; SNES_WR_END = 1'b1;
      step();
      SNES_WR_END = 1'b0; IS_WRITABLE = 1'b0;
      step(3);
      check("we_low_cnt3", {31'd0, RAM_WE_N}, 32'd0);
      #1 RST = 1'b1;
      #1;
      check("arst_we_n", {31'd0, RAM_WE_N}, 32'd1);
      check("arst_doe", {31'd0, RAM_DOE}, 32'd0);
      check("arst_ce_n", {31'd0, RAM_CE_N}, 32'd1);
      check("arst_mcu_rdy", {31'd0, MCU_RDY}, 32'd1);
      check("arst_ovf_clear", {31'd0, SNES_OVF}, 32'd0);
      step(2);
      RST = 1'b0;
      lo = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (!RAM_CE_N) lo++;
      end
      check("no_resume_after_rst", lo, 0);

      step(2);
      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/rom_access_sequencer.md
# rom_access_sequencer

Sits directly downstream of the address decoder and turns its combinational ROM_ADDR / ROM_HIT / IS_WRITABLE result into timed cycles on the shared cartridge SRAM bus. SNES accesses get absolute priority. The MCU gets the bus in the gaps between them, through a single-outstanding request/ready handshake. All timing is counted in CLK cycles from the synchronized SNES strobes.

## Interface
- ROM_CYCLE_LEN, 7: CLK cycles per SRAM access, legal range 4..15.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- SNES_RD_START  in  1  one-cycle pulse: synchronized SNES read cycle has begun.
- SNES_WR_END  in  1  one-cycle pulse: synchronized SNES write strobe has ended, data is stable.
- ROM_ADDR  in  24  decoded SRAM address from the address decoder.
- ROM_HIT  in  1  the decoded address targets SRAM.
- IS_WRITABLE  in  1  the decoded address may be written.
- SNES_WRDATA  in  8  SNES data bus, captured with SNES_WR_END.
- SNES_RDDATA  out  8  last SRAM byte read for the SNES.
- MCU_RRQ  in  1  one-cycle MCU read request.
- MCU_WRQ  in  1  one-cycle MCU write request.
- MCU_ADDR  in  24  MCU target address.
- MCU_WRDATA  in  8  MCU write byte.
- MCU_RDDATA  out  8  MCU read result.
- MCU_RDY  out  1  high when the sequencer is idle toward the MCU and MCU_RDDATA is valid.
- RAM_ADDR  out  24  SRAM address pins.
- RAM_CE_N  out  1  SRAM chip enable, active low.
- RAM_OE_N  out  1  SRAM output enable, active low.
- RAM_WE_N  out  1  SRAM write enable, active low.
- RAM_DOUT  out  8  SRAM write data.
- RAM_DOE  out  1  SRAM data-bus drive enable.
- RAM_DIN  in  8  SRAM read data.
- SNES_OVF  out  1  sticky flag: a SNES request was lost.

## Operation
- States: IDLE, SNES_RD, SNES_WR, MCU_RD, MCU_WR. A 4-bit counter `cnt` runs 0..ROM_CYCLE_LEN-1 inside every non-IDLE state.
- **SNES capture**
  - On SNES_RD_START with ROM_HIT=1, the sequencer stores {rd, ROM_ADDR} in a one-entry SNES pending slot.
  - On SNES_WR_END with ROM_HIT=1 and IS_WRITABLE=1, it stores {wr, ROM_ADDR, SNES_WRDATA}.
  - A strobe that fails its gate is ignored: no bus activity.
- **MCU capture**
  - MCU_RRQ or MCU_WRQ while MCU_RDY=1 stores a one-entry MCU pending slot and drops MCU_RDY on the next edge.
  - Requests arriving while MCU_RDY=0 are ignored.
  - RRQ and WRQ in the same cycle: the read wins and the write is discarded.
- **Arbitration in IDLE**
  - A pending SNES slot starts first.
  - Otherwise a pending MCU slot starts.
  - An access in progress is never aborted.
  - A SNES request captured during an MCU access starts on the cycle after that access ends.
- **Overflow**
  - A SNES capture while the SNES slot is still pending (not yet started) overwrites the slot and sets SNES_OVF.
  - Only RST clears SNES_OVF.
- **Read access**
  - RAM_ADDR is loaded at state entry.
  - CE_N and OE_N are low for every cycle in the state.
  - RAM_DIN is sampled into SNES_RDDATA or MCU_RDDATA on the edge that leaves the state (cnt = ROM_CYCLE_LEN-1).
- **Write access**
  - RAM_ADDR, RAM_DOUT and RAM_DOE=1 are driven for all cycles in the state.
  - CE_N is low for all cycles.
  - WE_N is low only for cnt 1..ROM_CYCLE_LEN-2, giving one cycle of address/data setup and one cycle of hold.
- **MCU completion:** MCU_RDY returns to 1 on the edge that leaves MCU_RD or MCU_WR.
- RAM_ADDR holds its last value while in IDLE.

## Timing
- **Reset values:**
  - state IDLE, cnt 0, pending slots empty.
  - RAM_CE_N=1, RAM_OE_N=1, RAM_WE_N=1, RAM_DOE=0.
  - RAM_ADDR=0, RAM_DOUT=0, SNES_RDDATA=0, MCU_RDDATA=0.
  - MCU_RDY=1, SNES_OVF=0.
- Reset asserted mid-access forces all of the above asynchronously. No partial write may continue: WE_N goes high immediately.
- **SNES read from IDLE:**
  - pulse at cycle t; CE_N/OE_N low from t+1 through t+ROM_CYCLE_LEN.
  - SNES_RDDATA is valid from t+ROM_CYCLE_LEN+1; the sequencer is back in IDLE at the same cycle.
- **Worst-case SNES latency** (an MCU access has just started): start is delayed by ROM_CYCLE_LEN cycles, so data is valid by t+2·ROM_CYCLE_LEN+1.
- **Back-to-back:** with a pending slot, the next access starts on the cycle the previous one returns to IDLE, with no dead cycle in IDLE.
- Capture and start in the same cycle are allowed. A SNES strobe arriving in the last cycle of an access starts on the next cycle.

## Test plan
- **SNES read:** RST released; ROM_ADDR=0x012345, ROM_HIT=1, RAM_DIN=0xA5, SNES_RD_START pulse at t -> CE_N/OE_N low t+1..t+7, RAM_ADDR=0x012345, SNES_RDDATA=0xA5 at t+8.
- **Write gating:** SNES_WR_END with IS_WRITABLE=0 -> RAM_WE_N stays 1 throughout. Repeat with IS_WRITABLE=1, data 0x3C -> WE_N low exactly 5 cycles, RAM_DOUT=0x3C, RAM_DOE high for 7 cycles.
- **Priority:** MCU_RRQ at t, SNES_RD_START at t+2 -> MCU read completes at t+8 with MCU_RDY high; SNES read begins t+8 and SNES_RDDATA is valid at t+15.
- **Simultaneous requests:** SNES_RD_START and MCU_WRQ in the same cycle -> SNES read executes first, MCU write immediately after; MCU_RDY low until the write ends.
- **Overflow:** during a running MCU access, two SNES strobes 2 cycles apart -> SNES_OVF=1, only the second address is accessed, and SNES_OVF stays 1 until RST.
- **Reset mid-write:** RST asserted at cnt=3 of SNES_WR -> WE_N=1 and DOE=0 asynchronously, MCU_RDY=1; after release, no access resumes.
